// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline skid-register stage.
//
// Contents:
//   pipe_state_t   control FSM encoding (EMPTY / FULL / SKID)
//   PipeStateW     width of the state encoding
package pipe_pkg;

  localparam int unsigned PipeStateW = 2;

  // PS_EMPTY : no entry held
  // PS_FULL  : main entry valid, skid entry free
  // PS_SKID  : main and skid entries both valid, upstream stalled
  typedef enum logic [PipeStateW-1:0] {
    PS_EMPTY = 2'b00,
    PS_FULL  = 2'b01,
    PS_SKID  = 2'b10
  } pipe_state_t;

endpackage : pipe_pkg

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear.
//
// Parameters:
//   W       counter width in bits
// Ports:
//   clk_i   rising-edge clock
//   clr_i   synchronous clear to zero (wins over inc_i)
//   inc_i   increment request; ignored once the count reaches 2^W-1
//   cnt_o   current count
module pipe_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] CntMax = '1;

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule : pipe_sat_counter

// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with valid/ready handshake and a 2-entry skid buffer.
// Sits between processor pipeline stages and carries an N-bit stage bundle with
// full throughput under back-pressure. in_ready is driven straight from a flop,
// so there is no combinational path from out_ready to in_ready.
//
// Optional feature macro: PIPE_SKID_STATS_EN adds the stall_cnt port and a
// saturating stall-cycle counter.
//
// Parameters:
//   N          width of the data bundle
//   RESET_VAL  value loaded into main/skid on rst or flush (e.g. a NOP encoding)
//   CNT_W      stall counter width (only meaningful with PIPE_SKID_STATS_EN)
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   flush      synchronous squash of every held entry (rst has priority)
//   in_valid   upstream offers in_data
//   in_ready   this stage can accept (registered)
//   in_data    upstream bundle
//   out_valid  main entry holds valid data
//   out_ready  downstream accepts
//   out_data   main entry data
//   stall_cnt  cycles with out_valid & !out_ready, saturating (macro only)
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned   N         = 32,
  parameter logic [N-1:0]  RESET_VAL = '0,
  parameter int unsigned   CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data
`ifdef PIPE_SKID_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  pipe_state_t  state_q, state_d;
  logic [N-1:0] main_q, main_d;
  logic [N-1:0] skid_q, skid_d;
  logic         in_ready_q, in_ready_d;

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = out_valid & out_ready;

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    unique case (state_q)
      PS_EMPTY: begin
        if (in_xfer) begin
          state_d = PS_FULL;
          main_d  = in_data;
        end
      end
      PS_FULL: begin
        if (out_xfer) begin
          if (in_xfer) begin
            main_d = in_data;
          end else begin
            state_d = PS_EMPTY;
          end
        end else if (in_xfer) begin
          // Downstream stalled: park the new beat behind the main entry
          state_d = PS_SKID;
          skid_d  = in_data;
        end
      end
      PS_SKID: begin
        // in_ready is low here, so in_valid cannot transfer
        if (out_xfer) begin
          state_d = PS_FULL;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = PS_EMPTY;
      end
    endcase

    // Flush squashes both entries and any same-cycle input beat
    if (flush) begin
      state_d = PS_EMPTY;
      main_d  = RESET_VAL;
      skid_d  = RESET_VAL;
    end

    // Registered ready: low exactly when both entries are occupied
    in_ready_d = (state_d != PS_SKID);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= PS_EMPTY;
      main_q     <= RESET_VAL;
      skid_q     <= RESET_VAL;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign out_valid = (state_q != PS_EMPTY);
  assign in_ready  = in_ready_q;
  assign out_data  = main_q;

`ifdef PIPE_SKID_STATS_EN
  // Counts every stalled cycle, flush cycles included; only rst clears it
  pipe_sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk_i (clk),
    .clr_i (rst),
    .inc_i (out_valid & ~out_ready),
    .cnt_o (stall_cnt)
  );
`endif

endmodule : pipe_skid_reg
